simon_sequencer: RTL

SIMON_SEQUENCER -- requirements
Module: simon_sequencer

---
 rtl/simon_if.sv | 24 ++
 rtl/simon_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/simon_if.sv
// Game-side signal bundle for the Simon sequencer: start/seed and button
// inputs from the player side, highlight and status outputs from the sequencer.
interface simon_if;
    logic       start;
    logic [7:0] seed;
    logic       btn_valid;
    logic [1:0] btn_dir;
    logic       show_valid;
    logic [1:0] show_dir;
    logic [4:0] level;
    logic       busy;
    logic       win;
    logic       fail;

    modport master (
        output start, seed, btn_valid, btn_dir,
        input  show_valid, show_dir, level, busy, win, fail
    );

    modport slave (
        input  start, seed, btn_valid, btn_dir,
        output show_valid, show_dir, level, busy, win, fail
    );
endinterface

// File: rtl/simon_sequencer.sv
// Simon memory game sequencer: grows a random direction sequence one step per
// round, replays it with timed highlight/gap phases, then checks player presses.
module simon_sequencer #(
    parameter int unsigned MAX_LEN     = 16,
    parameter int unsigned SHOW_CYCLES = 25000000,
    parameter int unsigned GAP_CYCLES  = 12500000
) (
    input logic   clock,
    input logic   reset_n,
    simon_if.slave game
);

    localparam int unsigned CntMax = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned IdxW   = $clog2(MAX_LEN);
    localparam logic [CntW-1:0] ShowLast = CntW'(SHOW_CYCLES - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);
    localparam logic [4:0]      MaxLevel = 5'(MAX_LEN);

    typedef enum logic [2:0] {
        StIdle, StAdd, StShowOn, StShowOff, StInput, StWin, StFail
    } state_e;

    state_e          state_q, state_d;
    logic [4:0]      level_q, level_d;
    logic [4:0]      idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      lfsr_q, lfsr_d;
    logic            mem_we;
    logic [1:0]      mem [MAX_LEN];
    logic [1:0]      cur_step;
    logic            last_step;

    assign cur_step  = mem[idx_q[IdxW-1:0]];
    assign last_step = (idx_q == level_q - 5'd1);

    // Next-state and register update decode.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        mem_we  = 1'b0;
        unique case (state_q)
            StIdle, StWin, StFail: begin
                // start takes priority; btn_valid has no effect here
                if (game.start) begin
                    lfsr_d  = (game.seed == 8'h00) ? 8'hA5 : game.seed;
                    level_d = 5'd0;
                    idx_d   = 5'd0;
                    cnt_d   = '0;
                    state_d = StAdd;
                end
            end
            StAdd: begin
                mem_we  = 1'b1;
                level_d = level_q + 5'd1;
                lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                idx_d   = 5'd0;
                cnt_d   = '0;
                state_d = StShowOn;
            end
            StShowOn: begin
                if (cnt_q == ShowLast) begin
                    cnt_d   = '0;
                    state_d = StShowOff;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StShowOff: begin
                if (cnt_q == GapLast) begin
                    cnt_d = '0;
                    if (last_step) begin
                        idx_d   = 5'd0;
                        state_d = StInput;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = StShowOn;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StInput: begin
                if (game.btn_valid) begin
                    if (game.btn_dir != cur_step) begin
                        state_d = StFail;
                    end else if (!last_step) begin
                        idx_d = idx_q + 5'd1;
                    end else if (level_q < MaxLevel) begin
                        state_d = StAdd;
                    end else begin
                        state_d = StWin;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and control registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= StIdle;
            level_q <= 5'd0;
            idx_q   <= 5'd0;
            cnt_q   <= '0;
            lfsr_q  <= 8'h01;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
        end
    end

    // Step storage; contents are meaningless until written by ADD.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[level_q[IdxW-1:0]] <= lfsr_q[1:0];
        end
    end

    // Moore output decode.
    always_comb begin
        game.show_valid = (state_q == StShowOn);
        game.show_dir   = (state_q == StShowOn) ? cur_step : 2'b00;
        game.level      = level_q;
        game.busy       = !(state_q inside {StIdle, StWin, StFail});
        game.win        = (state_q == StWin);
        game.fail       = (state_q == StFail);
    end

endmodule
